// File: rtl/spim_boot_ctrl.sv
// ---------------------------------------------------------------------------
// spim_boot_ctrl
//
// Boot-time AHB master for the SPI flash memory slave. After a Start pulse
// it waits for the flash slave to report Initialized, writes the slave's
// control register once, then copies WORDS 32-bit words starting at
// SRC_BASE into the on-chip boot SRAM through a simple write port.
// Only one AHB transfer is ever outstanding: a NONSEQ address phase
// followed by IDLE for the whole data phase (SINGLE, word-sized).
//
// Ports
//   HCLK, HRST     clock, asynchronous active-high reset
//   Start          one-cycle request to begin a copy (IDLE/DONE/ERR only)
//   Abort          level; stop at the next safe point
//   SpiInit        Initialized flag from the flash slave
//   M_H*           AHB master interface (HSIZE/HBURST constant)
//   RAM_WE/ADDR/WDATA  boot SRAM write port, one strobe per copied word
//   Busy           copy in progress
//   Done, Error    sticky completion / non-OKAY flags, cleared by Start
// ---------------------------------------------------------------------------
module spim_boot_ctrl #(
    parameter logic [31:0] CTRL_ADDR = 32'h0800_000C,
    parameter logic [25:0] CTRL_WORD = 26'h003_0001,
    parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
    parameter int          WORDS     = 256,
    parameter int          RAM_AW    = 8
) (
    input  logic              HCLK,
    input  logic              HRST,
    input  logic              Start,
    input  logic              Abort,
    input  logic              SpiInit,
    output logic [31:0]       M_HADDR,
    output logic [1:0]        M_HTRANS,
    output logic              M_HWRITE,
    output logic [2:0]        M_HSIZE,
    output logic [2:0]        M_HBURST,
    output logic [31:0]       M_HWDATA,
    input  logic [31:0]       M_HRDATA,
    input  logic              M_HREADY,
    input  logic [1:0]        M_HRESP,
    output logic              RAM_WE,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic [31:0]       RAM_WDATA,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    localparam int              CW            = $clog2(WORDS) + 1;
    localparam logic [CW-1:0]   LAST_CNT      = CW'(WORDS - 1);
    localparam logic [1:0]      HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]      HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]      HRESP_OKAY    = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        CFG_A,
        CFG_D,
        RD_A,
        RD_D,
        DONE,
        ERR
    } bootState_t;

    bootState_t        stateReg, stateNext;
    logic [CW-1:0]     cntReg, cntNext;
    logic [31:0]       haddrReg, haddrNext;
    logic [1:0]        htransReg, htransNext;
    logic              hwriteReg, hwriteNext;
    logic [31:0]       hwdataReg, hwdataNext;
    logic              ramWeReg, ramWeNext;
    logic [RAM_AW-1:0] ramAddrReg, ramAddrNext;
    logic [31:0]       ramWdataReg, ramWdataNext;
    logic              busyReg, busyNext;
    logic              doneReg, doneNext;
    logic              errorReg, errorNext;
    logic [CW-1:0]     cntInc;

    // Flash byte address of word c; wraps modulo 2^32.
    function automatic logic [31:0] wordAddr(input logic [CW-1:0] c);
        return SRC_BASE + (32'(c) << 2);
    endfunction

    assign cntInc = cntReg + CW'(1);

    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        haddrNext    = haddrReg;
        htransNext   = htransReg;
        hwriteNext   = hwriteReg;
        hwdataNext   = hwdataReg;
        ramWeNext    = 1'b0;
        ramAddrNext  = ramAddrReg;
        ramWdataNext = ramWdataReg;
        busyNext     = busyReg;
        doneNext     = doneReg;
        errorNext    = errorReg;

        case (stateReg)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    stateNext = WAIT_INIT;
                    cntNext   = '0;
                    doneNext  = 1'b0;
                    errorNext = 1'b0;
                    busyNext  = 1'b1;
                end
            end

            WAIT_INIT: begin
                if (Abort) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end else if (SpiInit && M_HREADY) begin
                    stateNext  = CFG_A;
                    htransNext = HTRANS_NONSEQ;
                    hwriteNext = 1'b1;
                    haddrNext  = CTRL_ADDR;
                end
            end

            // Address phase: acceptance wins over Abort, which is then
            // honoured once the data phase completes.
            CFG_A: begin
                if (M_HREADY) begin
                    stateNext  = CFG_D;
                    htransNext = HTRANS_IDLE;
                    hwdataNext = {6'b0, CTRL_WORD};
                end else if (Abort) begin
                    stateNext  = IDLE;
                    htransNext = HTRANS_IDLE;
                    busyNext   = 1'b0;
                end
            end

            CFG_D: begin
                if (M_HREADY) begin
                    if (Abort) begin
                        stateNext = IDLE;
                        busyNext  = 1'b0;
                    end else if (M_HRESP != HRESP_OKAY) begin
                        stateNext = ERR;
                        errorNext = 1'b1;
                        busyNext  = 1'b0;
                    end else begin
                        stateNext  = RD_A;
                        htransNext = HTRANS_NONSEQ;
                        hwriteNext = 1'b0;
                        haddrNext  = wordAddr(cntReg);
                    end
                end
            end

            RD_A: begin
                if (M_HREADY) begin
                    stateNext  = RD_D;
                    htransNext = HTRANS_IDLE;
                end else if (Abort) begin
                    stateNext  = IDLE;
                    htransNext = HTRANS_IDLE;
                    busyNext   = 1'b0;
                end
            end

            // Data phase may stall for a long time; the next address phase
            // is launched straight from the completing edge so a zero-wait
            // slave sees one word every two cycles.
            RD_D: begin
                if (M_HREADY) begin
                    if (Abort) begin
                        stateNext = IDLE;
                        busyNext  = 1'b0;
                    end else if (M_HRESP != HRESP_OKAY) begin
                        stateNext = ERR;
                        errorNext = 1'b1;
                        busyNext  = 1'b0;
                    end else begin
                        ramWeNext    = 1'b1;
                        ramAddrNext  = RAM_AW'(cntReg);
                        ramWdataNext = M_HRDATA;
                        if (cntReg == LAST_CNT) begin
                            stateNext = DONE;
                            doneNext  = 1'b1;
                            busyNext  = 1'b0;
                        end else begin
                            cntNext    = cntInc;
                            stateNext  = RD_A;
                            htransNext = HTRANS_NONSEQ;
                            haddrNext  = wordAddr(cntInc);
                        end
                    end
                end
            end

            default: begin
                stateNext  = IDLE;
                htransNext = HTRANS_IDLE;
                busyNext   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            haddrReg    <= '0;
            htransReg   <= HTRANS_IDLE;
            hwriteReg   <= 1'b0;
            hwdataReg   <= '0;
            ramWeReg    <= 1'b0;
            ramAddrReg  <= '0;
            ramWdataReg <= '0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            errorReg    <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            haddrReg    <= haddrNext;
            htransReg   <= htransNext;
            hwriteReg   <= hwriteNext;
            hwdataReg   <= hwdataNext;
            ramWeReg    <= ramWeNext;
            ramAddrReg  <= ramAddrNext;
            ramWdataReg <= ramWdataNext;
            busyReg     <= busyNext;
            doneReg     <= doneNext;
            errorReg    <= errorNext;
        end
    end

    assign M_HADDR   = haddrReg;
    assign M_HTRANS  = htransReg;
    assign M_HWRITE  = hwriteReg;
    assign M_HSIZE   = 3'b010;
    assign M_HBURST  = 3'b000;
    assign M_HWDATA  = hwdataReg;
    assign RAM_WE    = ramWeReg;
    assign RAM_ADDR  = ramAddrReg;
    assign RAM_WDATA = ramWdataReg;
    assign Busy      = busyReg;
    assign Done      = doneReg;
    assign Error     = errorReg;

endmodule

// File: doc/spim_boot_ctrl.md
Name: spim_boot_ctrl

Overview:
- AHB master that sequences the SPI flash memory slave after power-up.
- Waits for the flash slave's Initialized flag, then writes its control register (scaler, read command, fast-read).
- Reads a block of WORDS 32-bit words from flash and writes them into on-chip boot SRAM through a simple write port.
- Sits between the boot sequencer (Start/Done) and the AHB fabric, ahead of CPU release from reset.

Parameters:
CTRL_ADDR, 32'h0800_000C, flash slave control register address (bit 27 set, [5:0]=6'b001100)
CTRL_WORD, 26'h003_0001, value written to control register: {FlashRst, FastRead, RDCMD[7:0], SCALER[15:0]}; default RDCMD=8'h03, SCALER=1
SRC_BASE, 32'h0000_0000, first flash byte address; must be word aligned
WORDS, 256, number of words copied; legal range 1..2^RAM_AW
RAM_AW, 8, SRAM word address width

Ports:
HCLK  in  1  clock
HRST  in  1  reset, asynchronous, active-high
Start  in  1  one-cycle request to begin a copy
Abort  in  1  level; stop copy at next safe point
SpiInit  in  1  Initialized flag from flash slave
M_HADDR  out  32  AHB address
M_HTRANS  out  2  AHB transfer type (IDLE 2'b00 / NONSEQ 2'b10 only)
M_HWRITE  out  1  AHB write
M_HSIZE  out  3  always 3'b010
M_HBURST  out  3  always 3'b000 (SINGLE)
M_HWDATA  out  32  AHB write data
M_HRDATA  in  32  AHB read data
M_HREADY  in  1  AHB ready (shared)
M_HRESP  in  2  AHB response
RAM_WE  out  1  SRAM write strobe, one cycle per word
RAM_ADDR  out  RAM_AW  SRAM word address
RAM_WDATA  out  32  SRAM write data
Busy  out  1  copy in progress
Done  out  1  sticky: copy completed
Error  out  1  sticky: non-OKAY response received

Behaviour:
- Reset (async, HRST=1): FSM=IDLE; M_HTRANS=IDLE, M_HADDR=0, M_HWRITE=0, M_HWDATA=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0, Busy=0, Done=0, Error=0, word counter=0. Reset mid-copy abandons everything; no further RAM_WE.
- All outputs registered. One transfer outstanding at a time: NONSEQ address phase, then IDLE during its data phase. No pipelining, no bursts.
- FSM states: IDLE, WAIT_INIT, CFG_A, CFG_D, RD_A, RD_D, DONE, ERR.
- IDLE/DONE/ERR:
  - Start=1 -> WAIT_INIT; clear Done, Error and counter; Busy=1.
  - Start is ignored in all other states.
- WAIT_INIT: SpiInit=1 && M_HREADY=1 -> CFG_A.
- CFG_A: drive NONSEQ, HWRITE=1, HADDR=CTRL_ADDR.
  - Edge with M_HREADY=1 accepts the address -> CFG_D.
  - Otherwise hold all address-phase signals.
- CFG_D: HTRANS=IDLE; HWDATA={6'b0, CTRL_WORD} held until M_HREADY=1.
  - M_HRESP!=OKAY -> ERR; else -> RD_A.
- RD_A: drive NONSEQ, HWRITE=0, HADDR=SRC_BASE+{cnt,2'b00}; on accept -> RD_D.
- RD_D: HTRANS=IDLE; wait for M_HREADY=1 (flash slave stalls tens to thousands of cycles). At that edge:
  - OKAY: RAM_WDATA<=M_HRDATA, RAM_ADDR<=cnt[RAM_AW-1:0], RAM_WE<=1 for exactly one cycle.
    - cnt==WORDS-1 -> DONE.
    - Otherwise cnt<=cnt+1 -> RD_A.
  - Non-OKAY: no RAM_WE -> ERR.
- DONE: Done=1, Busy=0. ERR: Error=1, Busy=0. Both flags sticky until next Start.
- Abort:
  - In WAIT_INIT or CFG_A/RD_A before address acceptance -> IDLE next edge with HTRANS=IDLE.
  - In CFG_D/RD_D the data phase completes; read data is discarded (no RAM_WE) -> IDLE.
  - Done and Error stay 0.
- Simultaneous Abort and address acceptance (M_HREADY=1 in *_A): transfer accepted; abort handled in the data phase.
- Counter width clog2(WORDS)+1; address arithmetic is modulo 2^32.
- Minimum latency per word: 2 cycles with a zero-wait slave.

Test Plan:
- Reset: assert HRST mid-copy in RD_D -> all outputs 0 asynchronously; after release no bus activity until Start.
- Init gating: Start with SpiInit=0 for 20 cycles -> HTRANS stays IDLE. Then SpiInit=1 -> one NONSEQ write to 0x0800000C, HWDATA=0x00030001 in the next cycle.
- Copy, WORDS=4, zero-wait slave returning 0xA0+addr:
  - HADDR sequence 0,4,8,C.
  - RAM_WE four single-cycle pulses, RAM_ADDR 0..3, data 0xA0,0xA4,0xA8,0xAC.
  - Done=1, Busy=0.
- Wait states: M_HREADY low 40 cycles in each RD_D -> HTRANS remains IDLE, RAM_WE only after M_HREADY rises, data still correct.
- Error: ERROR response on word 2 -> no RAM_WE for word 2, Error=1, Done=0; a new Start clears Error and restarts at SRC_BASE.
- Abort: Abort during RD_D of word 1 -> transfer finishes without RAM_WE, FSM IDLE, Done=0; Start during the copy is ignored.
